// File: rtl/link_ddr_downstream_ch.sv
// Downstream DDR link channel: pairs received beats into words, buffers them in a
// credit-sized FIFO, and returns credits to the sender as decimated token toggles.
//
// state | meaning
// LOW   | next valid beat is the low half of a word
// HIGH  | low half captured; next valid beat completes the word
module link_ddr_downstream_ch #(
  parameter int beat_width_p          = 16,
  parameter int fifo_els_p            = 8,
  parameter int lg_token_decimation_p = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      io_valid_i,
  input  logic [beat_width_p-1:0]   io_data_i,
  output logic                      core_valid_o,
  output logic [2*beat_width_p-1:0] core_data_o,
  input  logic                      core_yumi_i,
  output logic                      token_o,
  output logic                      overflow_o
);

  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int dec_w_lp = (lg_token_decimation_p > 0) ? lg_token_decimation_p : 1;

  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(fifo_els_p);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(fifo_els_p - 1);
  localparam logic [dec_w_lp-1:0] dec_last_lp = dec_w_lp'((1 << lg_token_decimation_p) - 1);

  localparam logic [0:0] st_low_c  = 1'b0;
  localparam logic [0:0] st_high_c = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [beat_width_p-1:0]   low_q, low_d;
  logic [2*beat_width_p-1:0] mem_q [fifo_els_p];
  logic [2*beat_width_p-1:0] mem_d [fifo_els_p];
  logic [ptr_w_lp-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
  logic [dec_w_lp-1:0]       dec_q, dec_d;
  logic                      token_q, token_d;
  logic                      overflow_q, overflow_d;

  logic push_req, push_ok, pop, full;

  assign full     = (cnt_q == cnt_full_lp);
  assign pop      = core_yumi_i && (cnt_q != '0);
  assign push_req = (state_q == st_high_c) && io_valid_i;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    dec_d      = dec_q;
    token_d    = token_q;
    overflow_d = overflow_q;

    if (io_valid_i) begin
      if (state_q == st_low_c) begin
        low_d   = io_data_i;
        state_d = st_high_c;
      end else begin
        state_d = st_low_c;
      end
    end

    if (push_ok) begin
      mem_d[wptr_q] = {io_data_i, low_q};
      wptr_d        = (wptr_q == ptr_last_lp) ? '0 : wptr_q + ptr_w_lp'(1);
    end
    if (push_req && !push_ok) overflow_d = 1'b1;

    if (pop) begin
      rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + ptr_w_lp'(1);
      if (dec_q == dec_last_lp) begin
        dec_d   = '0;
        token_d = ~token_q;
      end else begin
        dec_d = dec_q + dec_w_lp'(1);
      end
    end

    if (push_ok && !pop)      cnt_d = cnt_q + cnt_w_lp'(1);
    else if (pop && !push_ok) cnt_d = cnt_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= st_low_c;
      low_q      <= '0;
      for (int i = 0; i < fifo_els_p; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      dec_q      <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_q      <= low_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  assign core_valid_o = (cnt_q != '0);
  assign core_data_o  = mem_q[rptr_q];
  assign token_o      = token_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_link_ddr_downstream_ch.sv
// Directed bench for link_ddr_downstream_ch: beat pairing, FIFO order, overflow,
// token decimation and reset behaviour, with hand-computed expectations.
module tb_link_ddr_downstream_ch;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_valid_i;
  logic [15:0] io_data_i;
  logic        core_valid_o;
  logic [31:0] core_data_o;
  logic        core_yumi_i;
  logic        token_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  link_ddr_downstream_ch #(
    .beat_width_p(16),
    .fifo_els_p(8),
    .lg_token_decimation_p(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_valid_i(io_valid_i),
    .io_data_i(io_data_i),
    .core_valid_o(core_valid_o),
    .core_data_o(core_data_o),
    .core_yumi_i(core_yumi_i),
    .token_o(token_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then observe 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic y);
    @(negedge clk);
    io_valid_i  = v;
    io_data_i   = d;
    core_yumi_i = y;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    io_valid_i = 1'b0; io_data_i = '0; core_yumi_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] lo, input logic [15:0] hi);
    cycle(1'b1, lo, 1'b0);
    cycle(1'b1, hi, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_valid_i = 1'b0; io_data_i = '0; core_yumi_i = 1'b0;
    #12;
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", core_valid_o); end
    total++; if (token_o !== 1'b0) begin bad++; $display("FAIL reset_token got=%b exp=0", token_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1'b1, 16'h1111, 1'b0);
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL basic_low_only got=%b exp=0", core_valid_o); end
    cycle(1'b1, 16'h2222, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", core_valid_o); end
    total++; if (core_data_o !== 32'h2222_1111) begin bad++; $display("FAIL basic_data got=%h exp=22221111", core_data_o); end
    cycle(1'b0, 16'h0000, 1'b1);
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", core_valid_o); end
  endtask

  task automatic test_gap();
    do_reset();
    cycle(1'b1, 16'hAAAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'hFFFF, 1'b0);
      total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL gap_idle%0d got=%b exp=0", i, core_valid_o); end
    end
    cycle(1'b1, 16'hBBBB, 1'b0);
    total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b exp=1", core_valid_o); end
    total++; if (core_data_o !== 32'hBBBB_AAAA) begin bad++; $display("FAIL gap_data got=%h exp=bbbbaaaa", core_data_o); end
    cycle(1'b0, 16'h0000, 1'b1);
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL gap_one_word got=%b exp=0", core_valid_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'(i), 16'h0000);
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", overflow_o); end
    push_word(16'h0008, 16'h0000);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
    for (int i = 0; i < 8; i++) begin
      total++; if (core_data_o !== 32'(i)) begin bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, core_data_o, 32'(i)); end
      cycle(1'b0, 16'h0000, 1'b1);
    end
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_ninth_absent got=%b exp=0", core_valid_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'(16'h10 + i), 16'h0000);
    cycle(1'b1, 16'h0099, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1);
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", overflow_o); end
    for (int i = 1; i < 9; i++) begin
      logic [31:0] exp;
      exp = (i < 8) ? 32'(16'h10 + i) : 32'h0000_0099;
      total++; if (core_valid_o !== 1'b1 || core_data_o !== exp) begin
        bad++; $display("FAIL fullpop_entry%0d got=%b/%h exp=1/%h", i, core_valid_o, core_data_o, exp);
      end
      cycle(1'b0, 16'h0000, 1'b1);
    end
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", core_valid_o); end
  endtask

  task automatic test_token();
    logic exp_tok;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'(i), 16'h0000);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 16'h0000, 1'b1);
      exp_tok = (k >= 4 && k < 8);
      total++; if (token_o !== exp_tok) begin bad++; $display("FAIL token_pop%0d got=%b exp=%b", k, token_o, exp_tok); end
    end
    for (int k = 0; k < 5; k++) cycle(1'b0, 16'h0000, 1'b1);
    total++; if (token_o !== 1'b0) begin bad++; $display("FAIL token_empty_yumi got=%b exp=0", token_o); end
    for (int i = 0; i < 4; i++) push_word(16'(i), 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 16'h0000, 1'b1);
      exp_tok = (k == 4);
      total++; if (token_o !== exp_tok) begin bad++; $display("FAIL token_again%0d got=%b exp=%b", k, token_o, exp_tok); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_word(16'hA001, 16'hA002);
    cycle(1'b1, 16'hB001, 1'b0);
    cycle(1'b1, 16'hB002, 1'b1);
    total++; if (core_valid_o !== 1'b1 || core_data_o !== 32'hB002_B001) begin
      bad++; $display("FAIL b2b_occ1 got=%b/%h exp=1/b002b001", core_valid_o, core_data_o);
    end
    cycle(1'b0, 16'h0000, 1'b1);
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", core_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(16'h0001, 16'h0002);
    cycle(1'b1, 16'h5555, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({core_valid_o, token_o, overflow_o} !== 3'b000) begin
      bad++; $display("FAIL midrst_outputs got=%b exp=000", {core_valid_o, token_o, overflow_o});
    end
    cycle(1'b1, 16'h7777, 1'b1);
    cycle(1'b1, 16'h8888, 1'b1);
    total++; if ({core_valid_o, token_o, overflow_o} !== 3'b000) begin
      bad++; $display("FAIL midrst_ignore got=%b exp=000", {core_valid_o, token_o, overflow_o});
    end
    @(negedge clk);
    rst = 1'b0; io_valid_i = 1'b0; core_yumi_i = 1'b0;
    cycle(1'b1, 16'h3333, 1'b0);
    total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_low_first got=%b exp=0", core_valid_o); end
    cycle(1'b1, 16'h4444, 1'b0);
    total++; if (core_data_o !== 32'h4444_3333) begin bad++; $display("FAIL midrst_data got=%h exp=44443333", core_data_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_full_pop();
    test_token();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
